// File: rtl/conv_im2col_feeder.sv
// Im2col feeder: buffers a raster pixel stream in a 4-row circular line buffer and
// emits one block of OUT_W 3x3 windows per output row over a valid/ready handshake.
module conv_im2col_feeder #(
    parameter int unsigned IMG_W    = 28,
    parameter int unsigned IMG_H    = 28,
    parameter int unsigned IN_WIDTH = 8
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_pix_valid,
    output logic                                   o_pix_ready,
    input  logic [IN_WIDTH-1:0]                    i_pix,
    output logic                                   o_post_valid,
    input  logic                                   i_post_ready,
    output logic [IMG_W-3:0][8:0][IN_WIDTH-1:0]    o_win,
    output logic                                   o_frame_done
);

    localparam int unsigned OUT_W  = IMG_W - 2;
    localparam int unsigned OUT_H  = IMG_H - 2;
    localparam int unsigned N_SLOT = 4;
    localparam int unsigned CW     = $clog2(IMG_W);
    localparam int unsigned RW     = $clog2(IMG_H + 4);
    localparam int unsigned OW     = $clog2(OUT_H + 1);

    logic [CW-1:0]       r_rx_col;
    logic [RW-1:0]       r_rx_row;
    logic [OW-1:0]       r_out_row;
    logic                r_frame_done;
    logic [IN_WIDTH-1:0] r_buf [N_SLOT][IMG_W];

    logic [CW-1:0]       w_rx_col_nxt;
    logic [RW-1:0]       w_rx_row_nxt;
    logic [OW-1:0]       w_out_row_nxt;
    logic                w_done_nxt;
    logic [RW-1:0]       w_out_ext;
    logic                w_pix_fire;
    logic                w_blk_fire;
    logic                w_last_col;
    logic                w_last_blk;
    logic [1:0]          w_wr_slot;
    logic [1:0]          w_rd_slot [3];

    // Handshake qualifiers are pure functions of the counters.
    assign w_out_ext    = RW'(r_out_row);
    assign o_pix_ready  = (r_rx_row < RW'(IMG_H)) && (r_rx_row <= w_out_ext + RW'(3));
    assign o_post_valid = (r_rx_row >= w_out_ext + RW'(3));
    assign w_pix_fire   = i_pix_valid & o_pix_ready;
    assign w_blk_fire   = o_post_valid & i_post_ready;
    assign w_last_col   = (r_rx_col == CW'(IMG_W - 1));
    assign w_last_blk   = (r_out_row == OW'(OUT_H - 1));
    assign w_wr_slot    = 2'(r_rx_row);
    assign o_frame_done = r_frame_done;

    // Next-state for counters; end-of-frame clear overrides the receive side.
    always_comb begin
        w_rx_col_nxt  = r_rx_col;
        w_rx_row_nxt  = r_rx_row;
        w_out_row_nxt = r_out_row;
        w_done_nxt    = 1'b0;
        if (w_pix_fire) begin
            if (w_last_col) begin
                w_rx_col_nxt = '0;
                w_rx_row_nxt = r_rx_row + RW'(1);
            end else begin
                w_rx_col_nxt = r_rx_col + CW'(1);
            end
        end
        if (w_blk_fire) begin
            if (w_last_blk) begin
                w_out_row_nxt = '0;
                w_rx_row_nxt  = '0;
                w_rx_col_nxt  = '0;
                w_done_nxt    = 1'b1;
            end else begin
                w_out_row_nxt = r_out_row + OW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_col     <= '0;
            r_rx_row     <= '0;
            r_out_row    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_rx_col     <= w_rx_col_nxt;
            r_rx_row     <= w_rx_row_nxt;
            r_out_row    <= w_out_row_nxt;
            r_frame_done <= w_done_nxt;
        end
    end

    // Line buffer: image row r lives in slot r mod 4.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < N_SLOT; s++) begin
                for (int c = 0; c < IMG_W; c++) begin
                    r_buf[s][c] <= '0;
                end
            end
        end else if (w_pix_fire) begin
            r_buf[w_wr_slot][r_rx_col] <= i_pix;
        end
    end

    // Window k of column c reads row out_row+k/3, column c+k%3.
    for (genvar g = 0; g < 3; g++) begin : g_rd_slot
        assign w_rd_slot[g] = 2'(r_out_row) + 2'(g);
    end

    for (genvar c = 0; c < OUT_W; c++) begin : g_col
        for (genvar k = 0; k < 9; k++) begin : g_tap
            assign o_win[c][k] = r_buf[w_rd_slot[k/3]][c + (k%3)];
        end
    end

endmodule

// File: tb/tb_conv_im2col_feeder.sv
// Directed bench for conv_im2col_feeder: reset, single frame, back-pressure,
// frame boundary, random bubbles over back-to-back frames and mid-frame reset.
module tb_conv_im2col_feeder;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int OUT_W = IMG_W - 2;
    localparam int OUT_H = IMG_H - 2;
    localparam int NPIX  = IMG_W * IMG_H;

    logic                          i_clk;
    logic                          i_rst_n;
    logic                          i_pix_valid;
    logic                          o_pix_ready;
    logic [7:0]                    i_pix;
    logic                          o_post_valid;
    logic                          i_post_ready;
    logic [OUT_W-1:0][8:0][7:0]    o_win;
    logic                          o_frame_done;

    conv_im2col_feeder #(.IMG_W(IMG_W), .IMG_H(IMG_H), .IN_WIDTH(8)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_pix_valid  (i_pix_valid),
        .o_pix_ready  (o_pix_ready),
        .i_pix        (i_pix),
        .o_post_valid (o_post_valid),
        .i_post_ready (i_post_ready),
        .o_win        (o_win),
        .o_frame_done (o_frame_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pix_total, blk_total, ndone, stalls, f_base, n_target;
    int first_valid_cyc, fire83_cyc, fire111_cyc, ready_drop_cyc, last_fire_cyc;
    bit chk_boundary;
    byte unsigned blk0_col0 [9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
    logic [OUT_W-1:0][8:0][7:0] held;

    // Reference pixel pattern; frame 0 is (28r+c)&0xFF.
    function automatic logic [7:0] pix(input int f, input int r, input int c);
        int v;
        v = r * IMG_W + c;
        if (f == 0) return 8'(v);
        return 8'(v * (2 * f + 1) + 17 * f + (r ^ c));
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input int f, input int row);
        logic [OUT_W-1:0][8:0][7:0] e;
        int bc, bk;
        bc = -1;
        bk = -1;
        for (int c = 0; c < OUT_W; c++) begin
            for (int k = 0; k < 9; k++) begin
                e[c][k] = pix(f, row + k / 3, c + k % 3);
                if (bc < 0 && o_win[c][k] !== e[c][k]) begin
                    bc = c;
                    bk = k;
                end
            end
        end
        checks++;
        assert (o_win === e) else begin
            errors++;
            $error("FAIL block f%0d row%0d: win[%0d][%0d] observed %0h expected %0h",
                   f, row, bc, bk, o_win[bc][bk], e[bc][bk]);
        end
    endtask

    task automatic start(input int fb, input int n);
        pix_total = 0; blk_total = 0; ndone = 0; stalls = 0;
        f_base = fb; n_target = n;
        first_valid_cyc = -1; fire83_cyc = -1; fire111_cyc = -1;
        ready_drop_cyc = -1; last_fire_cyc = -1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (3) begin
            i_pix_valid  = 1'($urandom);
            i_post_ready = 1'($urandom);
            i_pix        = 8'($urandom);
            @(posedge i_clk);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_pix_valid = 1'b0;
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    // One clock: drive inputs, sample settled outputs, track fires, advance.
    task automatic cycle(input bit want_v, input bit want_r);
        int fr, pi;
        fr = pix_total / NPIX;
        pi = pix_total % NPIX;
        i_pix_valid  = want_v && (pix_total < n_target * NPIX);
        i_pix        = i_pix_valid ? pix(f_base + fr, pi / IMG_W, pi % IMG_W) : 8'($urandom);
        i_post_ready = want_r;
        #1;
        if (i_pix_valid && !o_pix_ready) stalls++;
        if (!o_pix_ready && ready_drop_cyc < 0) ready_drop_cyc = cyc;
        if (o_post_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (o_frame_done) begin
            ndone++;
            chk("frame_done_timing", cyc, last_fire_cyc + 1);
        end
        if (i_pix_valid && o_pix_ready) begin
            if (pix_total == 83) fire83_cyc = cyc;
            if (pix_total == 111) fire111_cyc = cyc;
            if (chk_boundary && pi == 0 && pix_total > 0)
                chk("frame_boundary_accept", cyc, last_fire_cyc + 1);
            pix_total++;
        end
        if (o_post_valid && i_post_ready) begin
            if (f_base + blk_total / OUT_H == 0 && blk_total % OUT_H == 0)
                for (int k = 0; k < 9; k++) chk("blk0_col0_tap", int'(o_win[0][k]), int'(blk0_col0[k]));
            if (f_base + blk_total / OUT_H == 0 && blk_total % OUT_H == OUT_H - 1)
                chk("blk25_col25_tap8", int'(o_win[25][8]), 15);
            chk_blk(f_base + blk_total / OUT_H, blk_total % OUT_H);
            if (blk_total % OUT_H == OUT_H - 1) last_fire_cyc = cyc;
            blk_total++;
        end
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, int'(o_pix_ready), 1);
        chk({tag, "_valid"}, int'(o_post_valid), 0);
        chk({tag, "_done"}, int'(o_frame_done), 0);
        chk({tag, "_win_zero"}, int'(o_win !== '0), 0);
    endtask

    task automatic full_frame_checks(input string tag);
        for (int n = 0; n < 3000 && ndone < 1; n++) cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b1, 1'b1);
        chk({tag, "_first_valid"}, first_valid_cyc, fire83_cyc + 1);
        chk({tag, "_blocks"}, blk_total, OUT_H);
        chk({tag, "_done_pulses"}, ndone, 1);
        chk({tag, "_pixels"}, pix_total, NPIX);
        chk({tag, "_stalls"}, stalls, 0);
    endtask

    initial begin
        chk_boundary = 1'b0;
        i_rst_n = 1'b1;
        i_pix_valid = 1'b0;
        i_post_ready = 1'b0;
        i_pix = '0;
        start(0, 1);
        #2;

        // Reset with random inputs, then idle after release.
        i_rst_n = 1'b0;
        repeat (4) begin
            i_pix_valid  = 1'($urandom);
            i_post_ready = 1'($urandom);
            i_pix        = 8'($urandom);
            @(posedge i_clk);
            #1;
        end
        chk_idle("in_reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_pix_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk_idle("post_reset");

        // Single frame, continuous input and ready.
        start(0, 1);
        full_frame_checks("single");

        // Back-pressure from the start.
        do_reset();
        start(1, 1);
        repeat (200) cycle(1'b1, 1'b0);
        chk("bp_pixels_held", pix_total, 4 * IMG_W);
        chk("bp_ready_drop", ready_drop_cyc, fire111_cyc + 1);
        chk("bp_ready_low", int'(o_pix_ready), 0);
        chk("bp_valid_high", int'(o_post_valid), 1);
        held = o_win;
        repeat (20) cycle(1'b1, 1'b0);
        chk("bp_win_stable", int'(o_win !== held), 0);
        for (int n = 0; n < 3000 && ndone < 1; n++) cycle(1'b1, 1'b1);
        chk("bp_blocks", blk_total, OUT_H);
        chk("bp_pixels", pix_total, NPIX);

        // Frame boundary: second frame accepted the cycle after the last block fire.
        do_reset();
        start(3, 2);
        chk_boundary = 1'b1;
        for (int n = 0; n < 5000 && ndone < 2; n++) cycle(1'b1, 1'b1);
        chk_boundary = 1'b0;
        chk("bnd_blocks", blk_total, 2 * OUT_H);
        chk("bnd_done_pulses", ndone, 2);

        // Random bubbles over three back-to-back frames.
        do_reset();
        start(5, 3);
        for (int n = 0; n < 20000 && ndone < 3; n++)
            cycle($urandom_range(99) >= 30, $urandom_range(99) >= 50);
        repeat (3) cycle(1'b0, 1'b1);
        chk("rnd_blocks", blk_total, 3 * OUT_H);
        chk("rnd_done_pulses", ndone, 3);
        chk("rnd_pixels", pix_total, 3 * NPIX);

        // Mid-frame resets, then a fresh frame.
        do_reset();
        start(0, 1);
        for (int n = 0; n < 200 && pix_total < 50; n++) cycle(1'b1, 1'b1);
        do_reset();
        chk_idle("mid_reset_a");
        start(0, 1);
        for (int n = 0; n < 2000 && blk_total < 11; n++) cycle(1'b1, 1'b1);
        chk("mid_blocks_before_reset", blk_total, 11);
        do_reset();
        chk_idle("mid_reset_b");
        start(0, 1);
        full_frame_checks("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_im2col_feeder.md
# conv_im2col_feeder

Front-end producer for the conv→FC pipeline. It accepts a raster-order pixel stream of one IMG_H×IMG_W 8-bit image and holds it in a 4-row circular line buffer. For each of the OUT_H = IMG_H−2 output rows it emits one im2col block of OUT_W = IMG_W−2 windows, each window holding 3×3 pixels. Its output is the transmitter side of the conv stage's valid/ready input: 26×9 block, one handshake per output row, 26 handshakes per 28×28 frame, matching the FC stage's 26-step weight sequencing.

## Interface
Parameters
- IMG_W, 28, image width in pixels; OUT_W = IMG_W−2.
- IMG_H, 28, image height in rows; OUT_H = IMG_H−2.
- IN_WIDTH, 8, pixel width in bits.

Ports
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_pix_valid  in  1  pixel stream valid.
- o_pix_ready  out  1  pixel stream ready.
- i_pix  in  IN_WIDTH  pixel, raster order (row-major, column 0 first).
- o_post_valid  out  1  im2col block valid.
- i_post_ready  in  1  downstream (conv) ready.
- o_win  out  [OUT_W−1:0][8:0]×IN_WIDTH  window block; o_win[c][k] = pixel(out_row+k/3, c+k%3).
- o_frame_done  out  1  one-cycle pulse after the final block of a frame is accepted.

## Operation
- Counters:
  - rx_col: 0..IMG_W−1, column being written.
  - rx_row: 0..IMG_H, count of fully received rows.
  - out_row: 0..OUT_H−1, next block to emit.
- Line buffer: 4 slots × IMG_W × IN_WIDTH. Image row r is stored in slot r mod 4.
- Pixel fire = i_pix_valid & o_pix_ready.
  - On a pixel fire: write buf[rx_row mod 4][rx_col].
  - If rx_col == IMG_W−1: rx_col ← 0 and rx_row ← rx_row+1. Otherwise rx_col ← rx_col+1.
- o_pix_ready = (rx_row < IMG_H) & (rx_row ≤ out_row+3). Slot reuse is allowed only once the row it held is no longer needed.
- o_post_valid = (rx_row ≥ out_row+3). Combinational from counters.
- o_win is combinational from slots (out_row, out_row+1, out_row+2) mod 4. It is stable while o_post_valid & !i_post_ready, because those slots cannot be written in that condition.
- Block fire = o_post_valid & i_post_ready.
  - If out_row < OUT_H−1: out_row ← out_row+1.
  - If out_row == OUT_H−1: out_row ← 0, rx_row ← 0, rx_col ← 0, and o_frame_done ← 1 for the next cycle.
- Pixel fire and block fire in the same cycle are both applied. The end-of-frame clear cannot coincide with a pixel fire, since rx_row = IMG_H forces o_pix_ready = 0.
- Effective states:
  - FILL: rx_row < out_row+3.
  - EMIT: valid asserted.
  - DRAIN: rx_row = IMG_H, input closed.
  - The frame wraps to FILL on the last block fire.
- No arithmetic on pixels; pure data movement. Pixel values are passed bit-exact.

## Timing
- Reset (async, i_rst_n=0):
  - Counters and all buffer entries go to 0.
  - Outputs: o_pix_ready=1, o_post_valid=0, o_frame_done=0, o_win all 0.
- First block: o_post_valid rises the cycle after the fire of pixel 3·IMG_W−1 (pixel 83 at default).
- Steady state, with continuous input and i_post_ready=1: one block every IMG_W cycles; pixel input never stalls.
- Back-pressure: with i_post_ready held 0 at out_row=0, input continues through row 3. o_pix_ready drops the cycle after pixel 4·IMG_W−1 (pixel 111) fires.
- Next frame: accepted from the cycle after the final block fire, when o_pix_ready is again 1.
- o_frame_done: registered; exactly one cycle high per frame.
- Reset mid-frame discards all partial state. The next frame must begin again at pixel 0.

## Test plan
- Reset: hold i_rst_n=0 with random inputs → o_pix_ready=1, o_post_valid=0, o_frame_done=0, o_win=0. Release → still idle until pixels arrive.
- Single frame, p(r,c)=(28r+c)&0xFF, i_pix_valid=1, i_post_ready=1:
  - o_post_valid first high the cycle after pixel 83.
  - First block: o_win[0] = {0,1,2,28,29,30,56,57,58}.
  - Block 25: o_win[25][8] = 783&0xFF = 15.
  - Exactly 26 block fires, then one o_frame_done pulse.
- Back-pressure: i_post_ready=0 from the start → o_pix_ready falls after pixel 111. o_win is unchanged while held. Releasing ready → remaining blocks are correct and no pixels are lost.
- Random bubbles: 30% idle on i_pix_valid and 50% on i_post_ready, over 3 back-to-back frames with distinct patterns → every block matches the software im2col reference, and there are 3 o_frame_done pulses.
- Frame boundary: second frame presented with i_pix_valid=1 continuously → its first pixel is accepted exactly one cycle after the last block fire of frame 1.
- Mid-frame reset: assert i_rst_n=0 after 50 pixels and after block 10, then send a fresh frame → outputs identical to the single-frame case.
